// File: rtl/cic_decim_ctrl.sv
// Sequencer and output buffer for one CIC decimator: flush, warm-up discard,
// gain normalisation with saturation, and a small valid/ready output FIFO.
module cic_decim_ctrl #(
    parameter int CIC_WIDTH  = 38,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 6,
    parameter int DISCARD    = 3,
    parameter int FLUSH_CYC  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 cic_ce,
    output logic                 cic_reset,
    input  logic                 cic_ce_out,
    input  logic [CIC_WIDTH-1:0] cic_data,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output logic [1:0]           state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_WARMUP = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int DW = $clog2(DISCARD + 1);

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [DW-1:0] DISC_LAST  = DW'(DISCARD - 1);
    localparam logic [PW:0]   DEPTH_C    = (PW + 1)'(FIFO_DEPTH);

    localparam logic signed [CIC_WIDTH-1:0] SAT_MAX =
        {{(CIC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [CIC_WIDTH-1:0] SAT_MIN =
        {{(CIC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
    logic [DW-1:0]        disc_cnt_q, disc_cnt_d;
    logic                 cic_reset_q, cic_reset_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          drop_q, drop_d;
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]          count_q, count_d;

    logic                        clear_stats;
    logic signed [CIC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]        sample;
    logic                        full, pop, wr_req, wr, drop;

    assign shifted = $signed(cic_data) >>> SHIFT;

    always_comb begin
        if (shifted > SAT_MAX)
            sample = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        else if (shifted < SAT_MIN)
            sample = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        else
            sample = shifted[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        disc_cnt_d  = disc_cnt_q;
        clear_stats = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                    clear_stats = 1'b1;
                end
            end
            S_FLUSH: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    state_d    = S_WARMUP;
                    disc_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cic_ce_out) begin
                    // The pulse that completes the discard is itself dropped.
                    if (disc_cnt_q == DISC_LAST) state_d = S_RUN;
                    else                         disc_cnt_d = disc_cnt_q + 1'b1;
                end
            end
            default: begin
                if (!enable) state_d = S_IDLE;
            end
        endcase
        cic_reset_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    end

    assign cic_ce = in_valid && enable && ((state_q == S_WARMUP) || (state_q == S_RUN));

    always_comb begin
        full   = (count_q == DEPTH_C);
        pop    = (count_q != '0) && out_ready;
        wr_req = (state_q == S_RUN) && cic_ce_out;
        // A pop frees the slot this cycle, so a write into a full FIFO is still taken.
        wr     = wr_req && (!full || pop);
        drop   = wr_req && full && !pop;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr) begin
            mem_d[wr_ptr_q] = sample;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d = clear_stats ? 1'b0 : (overflow_q || drop);
        drop_d     = drop_q;
        if (clear_stats)                    drop_d = '0;
        else if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            disc_cnt_q  <= '0;
            cic_reset_q <= 1'b1;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            cic_reset_q <= cic_reset_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign cic_reset  = cic_reset_q;
    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_cic_decim_ctrl;

    logic clk, rst_n, en, iv, ce_o, rdy;
    logic signed [37:0] dat;
    logic cic_ce, cic_reset, out_valid, overflow;
    logic [15:0] out_data, drop_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // model
    int m_state, m_flush, m_disc, m_drop;
    bit m_ovf;
    int q[$];

    cic_decim_ctrl dut (
        .clk(clk), .reset_n(rst_n), .enable(en), .in_valid(iv),
        .cic_ce(cic_ce), .cic_reset(cic_reset), .cic_ce_out(ce_o), .cic_data(dat),
        .out_data(out_data), .out_valid(out_valid), .out_ready(rdy),
        .overflow(overflow), .drop_count(drop_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int msat(input logic signed [37:0] d);
        longint x;
        x = d;
        x = x >>> 6;
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    task automatic model_reset();
        m_state = 0; m_flush = 0; m_disc = 0; m_drop = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit full, pop, wr;
        int smp;
        full = (q.size() == 4);
        pop  = (q.size() != 0) && rdy;
        wr   = (m_state == 3) && ce_o;
        smp  = msat(dat);
        if (pop) q.delete(0);
        if (wr) begin
            if (full && !pop) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end else q.push_back(smp);
        end
        case (m_state)
            0: if (en) begin m_state = 1; m_flush = 0; m_ovf = 0; m_drop = 0; end
            1: if (!en) m_state = 0;
               else begin
                   m_flush++;
                   if (m_flush == 2) begin m_state = 2; m_disc = 0; end
               end
            2: if (!en) m_state = 0;
               else if (ce_o) begin
                   m_disc++;
                   if (m_disc == 3) m_state = 3;
               end
            default: if (!en) m_state = 0;
        endcase
    endtask

    task automatic compare();
        bit exp_rst, exp_ce;
        exp_rst = (m_state == 0) || (m_state == 1);
        exp_ce  = ((m_state == 2) || (m_state == 3)) && en && iv;
        chk("state", state, m_state);
        chk("cic_reset", cic_reset, exp_rst);
        chk("cic_ce", cic_ce, exp_ce);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chk("out_data", $signed(out_data), q[0]);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drop);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        if (!rst_n) model_reset();
        #1 compare();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic go_run();
        int n = 0;
        en = 1; ce_o = 0;
        repeat (3) tick();
        ce_o = 1;
        while (m_state != 3 && n < 20) begin tick(); n++; end
        ce_o = 0;
        chk("reach_run", m_state, 3);
    endtask

    initial begin
        rst_n = 0; en = 0; iv = 1; ce_o = 0; rdy = 0; dat = '0;
        model_reset();
        chk("pin_sat_pos", msat(38'sd4194304), 32767);
        chk("pin_sat_neg", msat(-38'sd4194304), -32768);
        chk("pin_sat_dc", msat(38'sd6400), 100);
        @(negedge clk);
        tick();
        #1;
        chk("rst_state", state, 0);
        chk("rst_cic_reset", cic_reset, 1);
        chk("rst_cic_ce", cic_ce, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_drop", drop_count, 0);
        rst_n = 1;
        tick();

        // DC input, ce_out every other cycle, downstream always ready
        en = 1; rdy = 1; dat = 38'sd6400;
        for (int i = 0; i < 40; i++) begin
            iv = i[0]; ce_o = i[0];
            tick();
        end
        ce_o = 1; tick(); ce_o = 0;
        #1 chk("dc_out_data", $signed(out_data), 100);

        // fresh start with empty FIFO
        en = 0; rdy = 1; tick(); tick(); tick();
        go_run();

        // saturation both directions
        rdy = 0; ce_o = 1;
        dat = 38'sd4194304;  tick();
        dat = -38'sd4194304; tick();
        ce_o = 0;
        #1 chk("sat_pos", $signed(out_data), 32767);
        rdy = 1; tick();
        #1 chk("sat_neg", $signed(out_data), -32768);
        tick();

        // overflow: 6 writes into a stalled 4-entry FIFO
        rdy = 0; ce_o = 1;
        for (int k = 1; k <= 6; k++) begin dat = 38'(64 * k); tick(); end
        ce_o = 0;
        #1;
        chk("ovf_drop", drop_count, 2);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", $signed(out_data), 1);

        // full FIFO, write coincides with pop
        ce_o = 1; rdy = 1; dat = 38'(64 * 7); tick();
        ce_o = 0; rdy = 0;
        #1;
        chk("fullpop_drop", drop_count, 2);
        chk("fullpop_head", $signed(out_data), 2);
        chk("fullpop_valid", out_valid, 1);
        rdy = 1; repeat (6) tick();

        // enable dropped mid-warmup, then re-raised
        en = 0; tick();
        en = 1; tick();
        #1;
        chk("reflush_state", state, 1);
        chk("reflush_ovf", overflow, 0);
        chk("reflush_drop", drop_count, 0);
        tick(); tick();
        ce_o = 1; tick();
        ce_o = 0; en = 0; tick();
        en = 1; tick(); tick(); tick();
        ce_o = 1; tick(); tick();
        #1 chk("warm_state", state, 2);
        tick();
        #1 chk("run_state", state, 3);
        ce_o = 0; rdy = 1; repeat (5) tick();

        // async reset mid-run with 3 entries held
        rdy = 0; ce_o = 1; dat = 38'sd640;
        repeat (3) tick();
        ce_o = 0; iv = 1;
        rst_n = 0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_cic_reset", cic_reset, 1);
        chk("arst_cic_ce", cic_ce, 0);
        tick();
        rst_n = 1; tick();

        // randomized soak
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 99) < 97);
            iv   = $urandom_range(0, 1);
            ce_o = ($urandom_range(0, 9) < 4);
            rdy  = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: dat = {$urandom, $urandom};
                1: dat = 38'($urandom_range(0, 4200000)) - 38'sd2100000;
                2: dat = 38'($urandom_range(0, 4000000));
                default: dat = -38'($urandom_range(0, 4000000));
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
